// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states and
// the latched operation descriptor.
package muldiv_unit_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Operation captured at start: kind of op plus operand signs for the fixup.
  typedef struct packed {
    logic is_div;
    logic neg_a;
    logic neg_b;
  } md_op_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Turns a raw magnitude product or {remainder, quotient} into signed HI/LO.
module muldiv_signfix
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  md_op_t             op,
  output logic [WIDTH-1:0]   hi_c,
  output logic [WIDTH-1:0]   lo_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_comb begin
    prod = (op.neg_a ^ op.neg_b) ? PW'(-raw) : raw;
    quo  = raw[WIDTH-1:0];
    rem  = raw[PW-1:WIDTH];
    hi_c = prod[PW-1:WIDTH];
    lo_c = prod[WIDTH-1:0];
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    if (op.is_div) begin
      lo_c = (op.neg_a ^ op.neg_b) ? WIDTH'(-quo) : quo;
      hi_c = op.neg_a ? WIDTH'(-rem) : rem;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  md_op_t           op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [PW-1:0]    acc_step;
  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fix_hi_c, fix_lo_c;

  // One iteration: shift-add multiply on {upper, multiplier} or restoring
  // divide on {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};
    if (op_q.is_div) begin
      acc_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    sgn   = (funct == F_MULT) || (funct == F_DIV);
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? WIDTH'(-a) : a;
    b_mag = b_neg ? WIDTH'(-b) : b;
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .raw  (acc_q),
    .op   (op_q),
    .hi_c (fix_hi_c),
    .lo_c (fix_lo_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          unique case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              op_d.is_div = (funct == F_DIV) || (funct == F_DIVU);
              op_d.neg_a  = a_neg;
              op_d.neg_b  = b_neg;
              acc_d       = {WIDTH'(0), a_mag};
              mcand_d     = b_mag;
              cnt_d       = CNT_W'(WIDTH - 1);
              state_d     = MD_RUN;
            end
            F_MTHI: hi_d = a;
            F_MTLO: lo_d = a;
            // Reads are served straight from hi/lo by the datapath.
            F_MFHI, F_MFLO: ;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MD_FIX: begin
        hi_d    = fix_hi_c;
        lo_d    = fix_lo_c;
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rstb;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present one start for a single edge; returns #1 after that edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    funct = f;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct = 6'h00;
    a     = '0;
    b     = '0;
  endtask

  // Count cycles with busy high, bounded so a stuck DUT still ends the run.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int cyc;
    issue(f, av, bv);
    wait_done(cyc);
    check({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rstb  = 1'b0;
    start = 1'b0;
    funct = 6'h00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // MULT -3 * 5, with a check that done is a single-cycle pulse.
    issue(6'h18, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy_start", 64'(busy), 64'd1);
    wait_done(cyc);
    check("mult_busy_cycles", 64'(cyc), 64'd33);
    check("mult_done", 64'(done), 64'd1);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    @(posedge clk);
    #1;
    check("mult_done_drop", 64'(done), 64'd0);
    check("mult_hi_hold", 64'(hi), 64'hFFFF_FFFF);

    run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_7_2", 6'h1B, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_by0", 6'h1B, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
    run_op("div_neg_by0", 6'h1A, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'h0000_0001);

    // MTHI then MTLO on consecutive cycles.
    issue(6'h11, 32'hCAFE_F00D, 32'd0);
    check("mthi_hi", 64'(hi), 64'hCAFE_F00D);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(6'h13, 32'h1234_5678, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h1234_5678);
    check("mtlo_hi_hold", 64'(hi), 64'hCAFE_F00D);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    // Unknown funct with start must not disturb anything.
    issue(6'h20, 32'h5555_5555, 32'd1);
    check("bad_funct_busy", 64'(busy), 64'd0);
    check("bad_funct_hi", 64'(hi), 64'hCAFE_F00D);
    check("bad_funct_lo", 64'(lo), 64'h1234_5678);

    // A start arriving mid-run is ignored.
    issue(6'h18, 32'd2, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    issue(6'h1B, 32'd100, 32'd7);
    wait_done(cyc);
    check("ign_busy_cycles", 64'(cyc + 10), 64'd33);
    check("ign_done", 64'(done), 64'd1);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd6);
    @(posedge clk);
    #1;

    // Reset mid-run discards the op and clears HI/LO.
    issue(6'h18, 32'd2, 32'd3);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    rstb = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_busy", 64'(busy), 64'd0);
    run_op("multu_4x4", 6'h19, 32'd4, 32'd4, 32'd0, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, driven by the R-type funct field once the main decoder selects the R-type ALU path.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- Exposes busy so the pipeline can stall MFHI/MFLO and a second muldiv op until the result is ready.

Parameters:
- WIDTH, 32: operand, HI and LO width; must be ≥4.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rstb  input  1  reset, asynchronous, active-low.
- start  input  1  request qualifier; valid funct/a/b this cycle.
- funct  input  6  MIPS funct field.
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source).
- b  input  WIDTH  rt operand (multiplier / divisor).
- busy  output  1  operation in flight; new starts are ignored.
- done  output  1  one-cycle pulse when HI/LO receive a mult/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: clears state to IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all working registers=0. Reset may assert at any time, including mid-operation. The in-flight op is discarded and HI/LO read 0.
- States:
  - IDLE: start && funct∈{MULT,MULTU,DIV,DIVU} → latch magnitudes, signs and op; go to RUN. busy=1 from the next cycle.
  - RUN: one radix-2 step per cycle for WIDTH cycles.
    - Multiply: shift-add on a 2·WIDTH product.
    - Divide: restoring shift-subtract.
    - counter counts WIDTH-1 down to 0, then go to FIX.
  - FIX: apply sign correction. Write hi/lo at the FIX→IDLE edge. done=1 for the cycle after that edge; busy=0 in that same cycle.
- Latency: start sampled at edge E0 → hi/lo valid and done=1 after edge E0+WIDTH+1. busy=1 for exactly WIDTH+1 cycles.
- MTHI/MTLO: start in IDLE → hi (resp. lo) ← a at the next edge. busy stays 0, done stays 0.
- Ignored inputs:
  - start while busy: no effect. The pipeline must stall on busy.
  - Other funct values with start: no effect.
- Multiply results:
  - MULTU: {hi,lo} = a·b unsigned.
  - MULT: {hi,lo} = a·b two's-complement. Compute the product of magnitudes and negate the 2·WIDTH result if sign(a)≠sign(b).
- Divide results:
  - DIVU: lo = a/b, hi = a%b unsigned.
  - DIV: quotient truncates toward zero. Remainder takes the dividend's sign.
  - Overflow case, most-negative ÷ -1: lo = most-negative, hi = 0.
  - Divide by zero (b=0, either signedness): lo = all ones, hi = a. This falls out of restoring division on magnitudes; for DIV, apply the normal sign rules to that raw result.
- hi/lo hold their value between writes. Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- mips_defines.v holds funct codes MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MTHI 6'h11, MTLO 6'h13, MFHI 6'h10, MFLO 6'h12.
- alu_defines.v holds the muldiv state encodings MD_IDLE, MD_RUN, MD_FIX.
- One natural sub-module: muldiv_signfix.
  - Combinational.
  - Inputs: raw 2·WIDTH product or quotient/remainder, and the sign flags.
  - Produces final hi/lo.
  - Unit-testable alone.
- The FSM, counter and datapath registers stay in muldiv_unit.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD (-3), b=5 → after 33 cycles, done pulses; hi=0xFFFFFFFF, lo=0xFFFFFFF1. busy=1 for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV with divide edge cases:
  - a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- MTHI a=0xCAFEF00D then MTLO a=0x12345678 on consecutive cycles → hi/lo updated one edge after each; busy and done stay 0.
- Ignored-start and reset checks:
  - MULT 2×3 started, then at RUN cycle 10 a DIVU start arrives → ignored; result hi=0, lo=6.
  - Repeat, then drop rstb at RUN cycle 10 → immediately busy=0, hi=lo=0, state IDLE.
  - After release, a new MULTU 4×4 yields lo=16.
